// File: rtl/tl_ram_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tl_ram_responder
//  Description : TileLink-UL responder serving single-beat Get, PutFullData
//                and PutPartialData from a local 64-bit register-array memory.
//                One request is outstanding at a time; the response is held
//                on the D channel until it is taken.
//  Revision    : 1.0 - initial release
// ============================================================================
module tl_ram_responder #(
    parameter int         DEPTH   = 64,
    parameter logic [5:0] SINK_ID = 6'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    // A channel
    input  logic [2:0]  a_opcode,
    input  logic [2:0]  a_param,
    input  logic [2:0]  a_size,
    input  logic [3:0]  a_source,
    input  logic [63:0] a_address,
    input  logic [7:0]  a_mask,
    input  logic [63:0] a_data,
    input  logic        a_corrupt,
    input  logic        a_valid,
    output logic        a_ready,
    // D channel
    output logic [2:0]  d_opcode,
    output logic [1:0]  d_param,
    output logic [2:0]  d_size,
    output logic [3:0]  d_source,
    output logic [5:0]  d_sink,
    output logic        d_denied,
    output logic [63:0] d_data,
    output logic        d_corrupt,
    output logic        d_valid,
    input  logic        d_ready
);

    localparam int         c_IDX_W       = $clog2(DEPTH);
    localparam logic [2:0] c_OP_PUT_FULL = 3'd0;
    localparam logic [2:0] c_OP_PUT_PART = 3'd1;
    localparam logic [2:0] c_OP_GET      = 3'd4;
    localparam logic [2:0] c_ACCESS_ACK  = 3'd0;
    localparam logic [2:0] c_ACK_DATA    = 3'd1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [63:0]        r_mem [DEPTH];
    logic [c_IDX_W-1:0] w_idx;
    logic               w_out_of_range;
    logic               w_is_get;
    logic               w_is_put;
    logic               w_denied;
    logic               w_accept;
    logic               w_wr_en;
    logic               w_unused;

    logic [2:0]  r_d_opcode;
    logic [2:0]  r_d_size;
    logic [3:0]  r_d_source;
    logic [5:0]  r_d_sink;
    logic        r_d_denied;
    logic [63:0] r_d_data;
    logic        r_d_corrupt;

    // Byte offset within the word and a_param carry no meaning here.
    assign w_unused = ^{a_param, a_address[2:0]};

    // Request decode: word index, range check and opcode classification.
    always_comb begin
        w_idx          = a_address[c_IDX_W+2:3];
        w_out_of_range = |a_address[63:c_IDX_W+3];
        w_is_get       = (a_opcode == c_OP_GET);
        w_is_put       = (a_opcode == c_OP_PUT_FULL) || (a_opcode == c_OP_PUT_PART);
        w_denied       = w_out_of_range || (a_size > 3'd3) || !(w_is_get || w_is_put);
        w_accept       = (r_state == IDLE) && a_valid;
        w_wr_en        = w_accept && w_is_put && !w_denied && !a_corrupt;
    end

    // State register; reset drops any pending response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and handshake outputs; a_ready is held low while in reset.
    always_comb begin
        w_state_next = r_state;
        a_ready      = 1'b0;
        d_valid      = 1'b0;
        case (r_state)
            IDLE: begin
                a_ready = rst_n;
                if (a_valid) begin
                    w_state_next = RESP;
                end
            end
            RESP: begin
                d_valid = 1'b1;
                if (d_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Memory array: cleared on reset, byte-lane write on an accepted Put.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            for (int k = 0; k < 8; k++) begin
                if (a_mask[k]) begin
                    r_mem[w_idx][8*k +: 8] <= a_data[8*k +: 8];
                end
            end
        end
    end

    // Response fields captured at accept and held until the next accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d_opcode  <= '0;
            r_d_size    <= '0;
            r_d_source  <= '0;
            r_d_sink    <= '0;
            r_d_denied  <= 1'b0;
            r_d_data    <= '0;
            r_d_corrupt <= 1'b0;
        end else if (w_accept) begin
            r_d_opcode  <= w_is_get ? c_ACK_DATA : c_ACCESS_ACK;
            r_d_size    <= a_size;
            r_d_source  <= a_source;
            r_d_sink    <= SINK_ID;
            r_d_denied  <= w_denied;
            r_d_data    <= (w_is_get && !w_denied) ? r_mem[w_idx] : 64'd0;
            r_d_corrupt <= w_is_get && w_denied;
        end
    end

    assign d_opcode  = r_d_opcode;
    assign d_param   = 2'd0;
    assign d_size    = r_d_size;
    assign d_source  = r_d_source;
    assign d_sink    = r_d_sink;
    assign d_denied  = r_d_denied;
    assign d_data    = r_d_data;
    assign d_corrupt = r_d_corrupt;

endmodule
`default_nettype wire
